// File: rtl/cnn_mem_pkg.sv
// rtl/cnn_mem_pkg.sv - shared FSM type, CSR map and region geometry for the CNN memory controller
package cnn_mem_pkg;

  localparam int MAX_REGIONS = 8;
  typedef int unsigned region_arr_t [MAX_REGIONS];

  localparam region_arr_t DEF_REGION_SIZE = '{10000, 400, 12800, 230400, 10600, 0, 0, 0};

  localparam int unsigned CSR_CTRL   = 16;
  localparam int unsigned CSR_STATUS = 17;
  localparam int unsigned CSR_IDX    = 18;
  localparam int unsigned OUT_BASE   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Base address of region idx in the flat weight RAM (sum of all earlier region sizes).
  function automatic int unsigned region_base(input region_arr_t sizes, input int idx);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      if (i < idx) sum += sizes[i];
    end
    return sum;
  endfunction

  localparam int unsigned TOTAL = region_base(DEF_REGION_SIZE, MAX_REGIONS);

endpackage

// File: rtl/cnn_sdp_ram.sv
// rtl/cnn_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module cnn_sdp_ram
  import cnn_mem_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Contents are never reset; only the read register is, so outputs are 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) o_rd_data <= '0;
    else       o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/cnn_layer_mem_ctrl.sv
// rtl/cnn_layer_mem_ctrl.sv - host-facing region loader, layer sequencer and output buffer for the CNN engine
module cnn_layer_mem_ctrl
  import cnn_mem_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 19,
  parameter int          NUM_REGIONS = 5,
  parameter region_arr_t REGION_SIZE = DEF_REGION_SIZE,
  parameter int          NUM_LAYERS  = 4,
  parameter int          OUT_DEPTH   = 16384,
  parameter bit          AUTO_START  = 1'b1,
  localparam int         WT_DEPTH    = int'(region_base(REGION_SIZE, NUM_REGIONS)),
  localparam int         WT_AW       = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1,
  localparam int         OUT_AW      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1,
  localparam int         IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              layer_start,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              layer_abort,
  input  logic              layer_done,
  input  logic [WT_AW-1:0]  eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_data,
  input  logic              eng_wr_en,
  input  logic [OUT_AW-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data
);

  localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int PTR_W  = $clog2(WT_DEPTH + 1);

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr [NUM_REGIONS];
  logic              r_err;
  logic              r_done;
  logic              r_busy;
  logic              r_auto_used;
  logic [IDX_W-1:0]  r_idx;
  logic              r_layer_start;
  logic              r_layer_abort;
  logic              r_rd_valid;
  logic              r_rd_is_out;
  logic [DATA_W-1:0] r_csr_rdata;

  logic [PTR_W-1:0]       w_size [NUM_REGIONS];
  logic [WT_AW-1:0]       w_base [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] w_loaded;
  logic                   w_all_loaded;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    assign w_size[g]   = PTR_W'(REGION_SIZE[g]);
    assign w_base[g]   = WT_AW'(region_base(REGION_SIZE, g));
    assign w_loaded[g] = (r_ptr[g] == w_size[g]);
  end

  assign w_all_loaded = &w_loaded;

  logic              w_hwr;
  logic              w_hrd;
  logic              w_is_stream;
  logic              w_is_ctrl;
  logic              w_is_out;
  logic [ADDR_W-1:0] w_out_off;
  logic [RSEL_W-1:0] w_rsel;
  logic              w_clear;
  logic              w_start;

  assign w_hwr       = chipselect & write;
  assign w_hrd       = chipselect & read;
  assign w_is_stream = (address < ADDR_W'(NUM_REGIONS));
  assign w_is_ctrl   = (address == ADDR_W'(CSR_CTRL));
  assign w_out_off   = address - ADDR_W'(OUT_BASE);
  assign w_is_out    = (address >= ADDR_W'(OUT_BASE)) && (w_out_off < ADDR_W'(OUT_DEPTH));
  assign w_rsel      = RSEL_W'(address);
  assign w_clear     = w_hwr & w_is_ctrl & writedata[0];
  assign w_start     = w_hwr & w_is_ctrl & writedata[1];

  logic             w_region_full;
  logic [WT_AW-1:0] w_wt_wr_addr;
  logic             w_stream_wr;
  logic             w_stream_ok;

  always_comb begin
    w_region_full = 1'b0;
    w_wt_wr_addr  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (w_rsel == RSEL_W'(i)) begin
        w_region_full = w_loaded[i];
        w_wt_wr_addr  = w_base[i] + WT_AW'(r_ptr[i]);
      end
    end
  end

  assign w_stream_wr = w_hwr & w_is_stream;
  assign w_stream_ok = w_stream_wr & ~r_busy & ~w_region_full;

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      for (int i = 0; i < NUM_REGIONS; i++) r_ptr[i] <= '0;
    end else if (w_stream_ok) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (w_rsel == RSEL_W'(i)) r_ptr[i] <= r_ptr[i] + PTR_W'(1);
      end
    end
  end

  // Clear outranks every other event, including a layer_done in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_auto_used   <= 1'b0;
      r_idx         <= '0;
      r_layer_start <= 1'b0;
      r_layer_abort <= 1'b0;
    end else begin
      r_layer_start <= 1'b0;
      r_layer_abort <= 1'b0;
      if (w_clear) begin
        r_layer_abort <= r_busy;
        r_state       <= S_IDLE;
        r_err         <= 1'b0;
        r_done        <= 1'b0;
        r_busy        <= 1'b0;
        r_auto_used   <= 1'b0;
        r_idx         <= '0;
      end else begin
        if (w_stream_wr && !w_stream_ok) r_err <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_all_loaded && ((AUTO_START && !r_auto_used) || w_start)) begin
              r_state       <= S_START;
              r_layer_start <= 1'b1;
              r_busy        <= 1'b1;
              r_auto_used   <= 1'b1;
              r_idx         <= '0;
              r_done        <= 1'b0;
            end else if (w_start) begin
              r_err <= 1'b1;
            end
          end
          S_START: r_state <= S_WAIT;
          S_WAIT: begin
            if (layer_done) r_state <= S_NEXT;
          end
          S_NEXT: begin
            if (r_idx == IDX_W'(NUM_LAYERS - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx         <= r_idx + IDX_W'(1);
              r_state       <= S_START;
              r_layer_start <= 1'b1;
            end
          end
          S_DONE: begin
            // An explicit start re-arms the auto trigger so the loaded regions run again.
            if (w_start) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b0;
              r_idx       <= '0;
              r_auto_used <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic [DATA_W-1:0] w_out_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_rd_is_out <= 1'b0;
      r_csr_rdata <= '0;
    end else begin
      r_rd_valid  <= w_hrd;
      r_rd_is_out <= w_hrd & w_is_out;
      r_csr_rdata <= '0;
      if (w_hrd) begin
        if (address == ADDR_W'(CSR_STATUS))
          r_csr_rdata <= DATA_W'({r_err, r_done, r_busy, w_loaded});
        else if (address == ADDR_W'(CSR_IDX))
          r_csr_rdata <= DATA_W'(r_idx);
      end
    end
  end

  assign readdata      = r_rd_is_out ? w_out_rdata : r_csr_rdata;
  assign readdatavalid = r_rd_valid;
  assign layer_start   = r_layer_start;
  assign layer_abort   = r_layer_abort;
  assign layer_idx     = r_idx;

  logic w_out_we;
  assign w_out_we = eng_wr_en && ({1'b0, eng_wr_addr} < (OUT_AW + 1)'(OUT_DEPTH));

  cnn_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (WT_DEPTH)
  ) u_weight_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_stream_ok),
    .i_wr_addr (w_wt_wr_addr),
    .i_wr_data (writedata),
    .i_rd_addr (eng_rd_addr),
    .o_rd_data (eng_rd_data)
  );

  cnn_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_out_we),
    .i_wr_addr (eng_wr_addr),
    .i_wr_data (eng_wr_data),
    .i_rd_addr (OUT_AW'(w_out_off)),
    .o_rd_data (w_out_rdata)
  );

endmodule

// File: tb/tb_cnn_layer_mem_ctrl.sv
// tb/tb_cnn_layer_mem_ctrl.sv - bench for cnn_layer_mem_ctrl with small regions, auto and manual start
module tb_cnn_layer_mem_ctrl;
  import cnn_mem_pkg::*;

  localparam int DW = 8, AW = 19, NR = 5, NL = 4, OD = 16, TOT = 12, WA = 4, OA = 4, IW = 2;
  localparam region_arr_t SZ = '{4, 2, 2, 2, 2, 0, 0, 0};
  localparam int BSZ [NR] = '{4, 2, 2, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cs0, cs1, write, read, ld0, ld1, eng_wr_en;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata, eng_wr_data;
  logic [WA-1:0] eng_rd_addr;
  logic [OA-1:0] eng_wr_addr;
  logic [DW-1:0] rdata0, rdata1, erd0, erd1;
  logic rdv0, rdv1, ls0, ls1, la0, la1;
  logic [IW-1:0] idx0, idx1;

  cnn_layer_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGIONS(NR), .REGION_SIZE(SZ),
    .NUM_LAYERS(NL), .OUT_DEPTH(OD), .AUTO_START(1'b1)) dut0 (
    .clk(clk), .reset(reset), .chipselect(cs0), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(rdata0), .readdatavalid(rdv0), .layer_start(ls0),
    .layer_idx(idx0), .layer_abort(la0), .layer_done(ld0), .eng_rd_addr(eng_rd_addr),
    .eng_rd_data(erd0), .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data));

  cnn_layer_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGIONS(NR), .REGION_SIZE(SZ),
    .NUM_LAYERS(NL), .OUT_DEPTH(OD), .AUTO_START(1'b0)) dut1 (
    .clk(clk), .reset(reset), .chipselect(cs1), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(rdata1), .readdatavalid(rdv1), .layer_start(ls1),
    .layer_idx(idx1), .layer_abort(la1), .layer_done(ld1), .eng_rd_addr(eng_rd_addr),
    .eng_rd_data(erd1), .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data));

  int errors = 0, checks = 0;

  // Reference model: per-region fill counts, sticky flags and expected memory images.
  int         m_ptr [2][NR];
  bit         m_err [2], m_done [2], m_busy [2];
  logic [7:0] m_ram [TOT];
  logic [7:0] m_out [OD];
  bit         m_out_wr [OD];

  int starts0 = 0, starts1 = 0, aborts0 = 0;
  int start_idx0 [$];

  always @(negedge clk) begin
    if (ls0 === 1'b1) begin starts0++; start_idx0.push_back(int'(idx0)); end
    if (ls1 === 1'b1) starts1++;
    if (la0 === 1'b1) aborts0++;
  end

  function automatic int base_of(input int r);
    int s = 0;
    for (int i = 0; i < r; i++) s += BSZ[i];
    return s;
  endfunction

  function automatic void model_stream(input int w, input int r, input logic [7:0] d);
    if (m_busy[w] || m_ptr[w][r] == BSZ[r]) m_err[w] = 1'b1;
    else begin
      if (w == 0) m_ram[base_of(r) + m_ptr[w][r]] = d;
      m_ptr[w][r]++;
    end
  endfunction

  function automatic void model_clear(input int w);
    for (int i = 0; i < NR; i++) m_ptr[w][i] = 0;
    m_err[w] = 1'b0; m_done[w] = 1'b0; m_busy[w] = 1'b0;
  endfunction

  function automatic logic [7:0] exp_status(input int w);
    logic [4:0] ld;
    for (int i = 0; i < NR; i++) ld[i] = (m_ptr[w][i] == BSZ[i]);
    return {m_err[w], m_done[w], m_busy[w], ld};
  endfunction

  task automatic hwrite(input int w, input int a, input logic [7:0] d);
    @(negedge clk);
    cs0 = (w == 0); cs1 = (w == 1); write = 1'b1; address = AW'(a); writedata = d;
    @(negedge clk);
    cs0 = 1'b0; cs1 = 1'b0; write = 1'b0;
  endtask

  task automatic hread(input int w, input int a, output logic [7:0] d, output logic v);
    @(negedge clk);
    cs0 = (w == 0); cs1 = (w == 1); read = 1'b1; address = AW'(a);
    @(negedge clk);
    cs0 = 1'b0; cs1 = 1'b0; read = 1'b0;
    d = (w == 0) ? rdata0 : rdata1;
    v = (w == 0) ? rdv0 : rdv1;
  endtask

  task automatic stream_write(input int w, input int r);
    logic [7:0] d;
    d = 8'($urandom);
    hwrite(w, r, d);
    model_stream(w, r, d);
  endtask

  task automatic eread(input int a, output logic [7:0] d);
    @(negedge clk);
    eng_rd_addr = WA'(a);
    @(negedge clk);
    d = erd0;
  endtask

  task automatic wait_start(input int w, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((w == 0 && ls0 === 1'b1) || (w == 1 && ls1 === 1'b1)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d; logic v;
    reset = 1'b1; cs0 = 0; cs1 = 0; write = 0; read = 0; address = '0; writedata = '0;
    ld0 = 0; ld1 = 0; eng_rd_addr = '0; eng_wr_en = 0; eng_wr_addr = '0; eng_wr_data = '0;
    for (int w = 0; w < 2; w++) model_clear(w);
    repeat (3) @(negedge clk);
    checks++; if ({rdv0, ls0, la0} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {rdv0, ls0, la0}); end
    checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx0); end
    checks++; if (rdata0 !== 8'h00 || erd0 !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h want 00/00", rdata0, erd0); end
    reset = 1'b0;
    hread(0, 17, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL reset_status got %h v=%b want 00 v=1", d, v); end
  endtask

  task automatic test_load_and_run;
    logic [7:0] d; logic v; bit seen;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < BSZ[r]; k++) stream_write(0, r);
    checks++; if (ls0 !== 1'b0) begin errors++; $display("FAIL start_early got %b want 0", ls0); end
    @(negedge clk);
    checks++; if (ls0 !== 1'b1 || idx0 !== 2'd0) begin errors++; $display("FAIL auto_start got ls=%b idx=%0d want 1/0", ls0, idx0); end
    m_busy[0] = 1'b1;
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_running got %h want %h", d, exp_status(0)); end
    for (int a = 0; a < TOT; a++) begin
      eread(a, d);
      checks++; if (d !== m_ram[a]) begin errors++; $display("FAIL weight_ram[%0d] got %h want %h", a, d, m_ram[a]); end
    end
    for (int k = 0; k < NL; k++) begin
      checks++; if (idx0 !== IW'(k)) begin errors++; $display("FAIL layer_idx got %0d want %0d", idx0, k); end
      @(negedge clk); ld0 = 1'b1;
      @(negedge clk); ld0 = 1'b0;
      if (k < NL - 1) begin
        wait_start(0, seen);
        checks++; if (!seen) begin errors++; $display("FAIL next_layer_start got none want pulse for layer %0d", k + 1); end
      end else repeat (3) @(negedge clk);
    end
    m_busy[0] = 1'b0; m_done[0] = 1'b1;
    #1;
    checks++; if (starts0 !== 4) begin errors++; $display("FAIL start_count got %0d want 4", starts0); end
    for (int i = 0; i < start_idx0.size() && i < 4; i++) begin
      checks++; if (start_idx0[i] !== i) begin errors++; $display("FAIL start_seq[%0d] got %0d want %0d", i, start_idx0[i], i); end
    end
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_done got %h want %h", d, exp_status(0)); end
    @(negedge clk); ld0 = 1'b1;
    @(negedge clk); ld0 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (starts0 !== 4) begin errors++; $display("FAIL no_retrigger got %0d starts want 4", starts0); end
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_after_stray_done got %h want %h", d, exp_status(0)); end
  endtask

  task automatic test_overflow;
    logic [7:0] d; logic v;
    stream_write(0, 0);
    eread(4, d);
    checks++; if (d !== m_ram[4]) begin errors++; $display("FAIL overflow_ram4 got %h want %h", d, m_ram[4]); end
    eread(3, d);
    checks++; if (d !== m_ram[3]) begin errors++; $display("FAIL overflow_ram3 got %h want %h", d, m_ram[3]); end
    stream_write(0, 4);
    eread(11, d);
    checks++; if (d !== m_ram[11]) begin errors++; $display("FAIL overflow_ram11 got %h want %h", d, m_ram[11]); end
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_err got %h want %h", d, exp_status(0)); end
  endtask

  task automatic test_out_buffer;
    logic [7:0] d; logic v; int a;
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, OD - 1));
      d = 8'($urandom);
      @(negedge clk); eng_wr_en = 1'b1; eng_wr_addr = OA'(a); eng_wr_data = d;
      m_out[a] = d; m_out_wr[a] = 1'b1;
    end
    @(negedge clk); eng_wr_en = 1'b1; eng_wr_addr = OA'(3); eng_wr_data = 8'hA5;
    m_out[3] = 8'hA5; m_out_wr[3] = 1'b1;
    @(negedge clk); eng_wr_en = 1'b0;
    cs0 = 1'b1; read = 1'b1; address = AW'(35);
    checks++; if (rdv0 !== 1'b0) begin errors++; $display("FAIL rdvalid_early got %b want 0", rdv0); end
    @(negedge clk); cs0 = 1'b0; read = 1'b0;
    checks++; if (rdv0 !== 1'b1 || rdata0 !== 8'hA5) begin errors++; $display("FAIL out3_read got %h v=%b want a5 v=1", rdata0, rdv0); end
    @(negedge clk);
    checks++; if (rdv0 !== 1'b0) begin errors++; $display("FAIL rdvalid_pulse got %b want 0", rdv0); end
    for (int i = 0; i < OD; i++) begin
      if (m_out_wr[i]) begin
        hread(0, 32 + i, d, v);
        checks++; if (d !== m_out[i] || v !== 1'b1) begin errors++; $display("FAIL out_read[%0d] got %h want %h", i, d, m_out[i]); end
      end
    end
    hread(0, 20, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h want 00", d); end
    hread(0, 2, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stream_port_read got %h want 00", d); end
    hread(0, 32 + OD, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL out_range_read got %h want 00", d); end
  endtask

  task automatic test_clear_mid_run;
    logic [7:0] d; logic v; bit seen; int base;
    hwrite(0, 16, 8'h01);
    model_clear(0);
    checks++; if (la0 !== 1'b0) begin errors++; $display("FAIL idle_clear_abort got %b want 0", la0); end
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_cleared got %h want %h", d, exp_status(0)); end
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < BSZ[r]; k++) stream_write(0, r);
    wait_start(0, seen);
    checks++; if (!seen) begin errors++; $display("FAIL reload_start got none want pulse"); end
    m_busy[0] = 1'b1;
    @(negedge clk); ld0 = 1'b1;
    @(negedge clk); ld0 = 1'b0;
    wait_start(0, seen);
    checks++; if (!seen || idx0 !== 2'd1) begin errors++; $display("FAIL second_layer got seen=%b idx=%0d want 1/1", seen, idx0); end
    #1 base = starts0;
    @(negedge clk);
    ld0 = 1'b1; cs0 = 1'b1; write = 1'b1; address = AW'(16); writedata = 8'h01;
    @(negedge clk);
    ld0 = 1'b0; cs0 = 1'b0; write = 1'b0;
    checks++; if (la0 !== 1'b1 || ls0 !== 1'b0) begin errors++; $display("FAIL abort_pulse got abort=%b start=%b want 1/0", la0, ls0); end
    @(negedge clk);
    checks++; if (la0 !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", la0); end
    model_clear(0);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (starts0 !== base || aborts0 !== 1) begin errors++; $display("FAIL after_abort got starts=%0d aborts=%0d want %0d/1", starts0, aborts0, base); end
    checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL abort_idx got %0d want 0", idx0); end
    hread(0, 17, d, v);
    checks++; if (d !== exp_status(0)) begin errors++; $display("FAIL status_aborted got %h want %h", d, exp_status(0)); end
    hread(0, 18, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL idx_reg got %h want 00", d); end
    for (int a = 0; a < TOT; a++) begin
      eread(a, d);
      checks++; if (d !== m_ram[a]) begin errors++; $display("FAIL ram_kept[%0d] got %h want %h", a, d, m_ram[a]); end
    end
  endtask

  task automatic test_no_autostart;
    logic [7:0] d; logic v; bit seen;
    hwrite(1, 16, 8'h01);
    model_clear(1);
    for (int k = 0; k < 4; k++) stream_write(1, 0);
    for (int k = 0; k < 2; k++) stream_write(1, 1);
    stream_write(1, 2);
    hwrite(1, 16, 8'h02);
    m_err[1] = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (starts1 !== 0) begin errors++; $display("FAIL partial_start got %0d starts want 0", starts1); end
    hread(1, 17, d, v);
    checks++; if (d !== exp_status(1)) begin errors++; $display("FAIL partial_status got %h want %h", d, exp_status(1)); end
    stream_write(1, 2);
    for (int r = 3; r < NR; r++)
      for (int k = 0; k < BSZ[r]; k++) stream_write(1, r);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (starts1 !== 0) begin errors++; $display("FAIL manual_no_auto got %0d starts want 0", starts1); end
    hwrite(1, 16, 8'h02);
    seen = (ls1 === 1'b1);
    if (!seen) wait_start(1, seen);
    checks++; if (!seen) begin errors++; $display("FAIL manual_start got none want pulse"); end
    m_busy[1] = 1'b1;
    hread(1, 17, d, v);
    checks++; if (d !== exp_status(1)) begin errors++; $display("FAIL manual_status got %h want %h", d, exp_status(1)); end
  endtask

  initial begin
    test_reset;
    test_load_and_run;
    test_overflow;
    test_out_buffer;
    test_clear_mid_run;
    test_no_autostart;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
